// File: rtl/dram_chip_pkg.sv
// Default geometry and shared types for the emulated DRAM device array.
// Provides widths, derived bank/row/column counts and the per-bank DQ type.
package dram_chip_pkg;

    localparam int DEF_BGWIDTH      = 2;
    localparam int DEF_BAWIDTH      = 2;
    localparam int DEF_ADDRWIDTH    = 17;
    localparam int DEF_COLWIDTH     = 10;
    localparam int DEF_DEVICE_WIDTH = 4;
    localparam int DEF_CHWIDTH      = 5;
    // Burst length is informational; beats are streamed one address per clock.
    localparam int BL               = 8;

    localparam int BANKGROUPS    = 2 ** DEF_BGWIDTH;
    localparam int BANKSPERGROUP = 2 ** DEF_BAWIDTH;
    localparam int COLS          = 2 ** DEF_COLWIDTH;
    localparam int EMU_ROWS      = 2 ** DEF_CHWIDTH;

    typedef logic [DEF_DEVICE_WIDTH-1:0] dq_t;

endpackage

// File: rtl/dram_bank.sv
// One DRAM bank: storage array plus registered read data.
// Ports: clk, reset_n (async low), rd_o_wr (1=write), dqin, dqout, row, column.
// Macro CHIP_RD_PIPE_EN adds a second read output stage (latency 2).
module dram_bank
    import dram_chip_pkg::*;
#(
    parameter int ADDRWIDTH    = DEF_ADDRWIDTH,
    parameter int COLWIDTH     = DEF_COLWIDTH,
    parameter int DEVICE_WIDTH = DEF_DEVICE_WIDTH,
    parameter int CHWIDTH      = DEF_CHWIDTH
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    rd_o_wr,
    input  logic [DEVICE_WIDTH-1:0] dqin,
    output logic [DEVICE_WIDTH-1:0] dqout,
    input  logic [ADDRWIDTH-1:0]    row,
    input  logic [COLWIDTH-1:0]     column
);

    localparam int NROWS = 2 ** CHWIDTH;
    localparam int NCOLS = 2 ** COLWIDTH;

    logic [DEVICE_WIDTH-1:0] mem [NROWS][NCOLS];

    // Only the emulated row bits index storage; upper bits alias.
    logic [CHWIDTH-1:0] row_idx;
    logic               unused_row_bits;

    assign row_idx         = row[CHWIDTH-1:0];
    assign unused_row_bits = ^row[ADDRWIDTH-1:CHWIDTH];

`ifdef CHIP_RD_PIPE_EN
    logic [DEVICE_WIDTH-1:0] rd_q;
    logic                    rd_vld;

    // Second stage advances only behind a real read, so writes hold it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q   <= '0;
            rd_vld <= 1'b0;
            dqout  <= '0;
        end else begin
            rd_vld <= !rd_o_wr;
            if (rd_o_wr) begin
                mem[row_idx][column] <= dqin;
            end else begin
                rd_q <= mem[row_idx][column];
            end
            if (rd_vld) begin
                dqout <= rd_q;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dqout <= '0;
        end else if (rd_o_wr) begin
            mem[row_idx][column] <= dqin;
        end else begin
            dqout <= mem[row_idx][column];
        end
    end
`endif

endmodule

// File: rtl/dram_chip.sv
// DRAM device array: BANKGROUPS x BANKSPERGROUP independent banks.
// Ports: clk, reset_n, per-bank rd_o_wr/dqin/dqout/row/column arrays.
// Macro CHIP_RD_PIPE_EN selects 2-clock read latency in every bank.
module dram_chip
    import dram_chip_pkg::*;
#(
    parameter int BGWIDTH      = DEF_BGWIDTH,
    parameter int BAWIDTH      = DEF_BAWIDTH,
    parameter int ADDRWIDTH    = DEF_ADDRWIDTH,
    parameter int COLWIDTH     = DEF_COLWIDTH,
    parameter int DEVICE_WIDTH = DEF_DEVICE_WIDTH,
    parameter int CHWIDTH      = DEF_CHWIDTH
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    rd_o_wr [2**BGWIDTH][2**BAWIDTH],
    input  logic [DEVICE_WIDTH-1:0] dqin    [2**BGWIDTH][2**BAWIDTH],
    output logic [DEVICE_WIDTH-1:0] dqout   [2**BGWIDTH][2**BAWIDTH],
    input  logic [ADDRWIDTH-1:0]    row     [2**BGWIDTH][2**BAWIDTH],
    input  logic [COLWIDTH-1:0]     column  [2**BGWIDTH][2**BAWIDTH]
);

    localparam int NUM_BG = 2 ** BGWIDTH;
    localparam int NUM_BA = 2 ** BAWIDTH;

    for (genvar g = 0; g < NUM_BG; g++) begin : g_grp
        for (genvar b = 0; b < NUM_BA; b++) begin : g_bank
            dram_bank #(
                .ADDRWIDTH    (ADDRWIDTH),
                .COLWIDTH     (COLWIDTH),
                .DEVICE_WIDTH (DEVICE_WIDTH),
                .CHWIDTH      (CHWIDTH)
            ) u_bank (
                .clk     (clk),
                .reset_n (reset_n),
                .rd_o_wr (rd_o_wr[g][b]),
                .dqin    (dqin[g][b]),
                .dqout   (dqout[g][b]),
                .row     (row[g][b]),
                .column  (column[g][b])
            );
        end
    end

endmodule

// File: tb/tb_dram_chip.sv
// Self-checking bench for dram_chip using a read-data scoreboard.
// Covers reset, burst, isolation, aliasing, concurrency, async reset.
module tb_dram_chip;
    import dram_chip_pkg::*;

`ifdef CHIP_RD_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    localparam int NG = BANKGROUPS;
    localparam int NB = BANKSPERGROUP;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rd_o_wr [NG][NB];
    dq_t         dqin    [NG][NB];
    dq_t         dqout   [NG][NB];
    logic [16:0] row     [NG][NB];
    logic [9:0]  column  [NG][NB];

    dram_chip dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rd_o_wr (rd_o_wr),
        .dqin    (dqin),
        .dqout   (dqout),
        .row     (row),
        .column  (column)
    );

    always #5 clk = ~clk;

    typedef struct {
        int  due;
        int  g;
        int  b;
        dq_t exp;
        bit  neq;
    } sb_t;

    sb_t q [$];
    int  cyc = 0;
    int  n_cmp = 0;
    int  n_bad = 0;

    dq_t burst [8];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)",
                     tag, obs, exp, cyc);
        end
    endtask

    task automatic idle();
        for (int g = 0; g < NG; g++) begin
            for (int b = 0; b < NB; b++) begin
                rd_o_wr[g][b] = 1'b0;
                dqin[g][b]    = '0;
                row[g][b]     = '0;
                column[g][b]  = '0;
            end
        end
    endtask

    task automatic tick();
        sb_t e;
        @(posedge clk);
        cyc++;
        #1;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            if (e.neq)
                check($sformatf("rd_neq[%0d][%0d]", e.g, e.b),
                      32'(dqout[e.g][e.b] === e.exp), 32'd0);
            else
                check($sformatf("rd[%0d][%0d]", e.g, e.b),
                      32'(dqout[e.g][e.b]), 32'(e.exp));
        end
    endtask

    task automatic wr(input int g, input int b, input int r,
                      input int c, input dq_t d);
        rd_o_wr[g][b] = 1'b1;
        row[g][b]     = 17'(r);
        column[g][b]  = 10'(c);
        dqin[g][b]    = d;
    endtask

    task automatic rd(input int g, input int b, input int r,
                      input int c, input dq_t d, input bit neq);
        rd_o_wr[g][b] = 1'b0;
        row[g][b]     = 17'(r);
        column[g][b]  = 10'(c);
        q.push_back('{due: cyc + LAT, g: g, b: b, exp: d, neq: neq});
    endtask

    task automatic drain();
        for (int i = 0; i < LAT + 1; i++) tick();
        check("sb_drain", 32'(q.size()), 32'd0);
        q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        for (int g = 0; g < NG; g++)
            for (int b = 0; b < NB; b++)
                check($sformatf("%s[%0d][%0d]", tag, g, b),
                      32'(dqout[g][b]), 32'd0);
    endtask

    initial begin
        burst = '{4'h3, 4'h9, 4'hD, 4'h5, 4'h1, 4'hF, 4'h6, 4'hC};
        reset_n = 1'b0;
        // Random traffic under reset; writes must be ignored.
        for (int k = 0; k < 2; k++) begin
            for (int g = 0; g < NG; g++)
                for (int b = 0; b < NB; b++) begin
                    rd_o_wr[g][b] = 1'($urandom_range(0, 1));
                    dqin[g][b]    = 4'($urandom);
                    row[g][b]     = 17'($urandom);
                    column[g][b]  = 10'($urandom);
                end
            tick();
        end
        check_all_zero("rst");
        reset_n = 1'b1;
        // First edge after release is a write everywhere: outputs stay 0.
        for (int g = 0; g < NG; g++)
            for (int b = 0; b < NB; b++)
                wr(g, b, 31, 1023, 4'($urandom_range(1, 15)));
        tick();
        check_all_zero("post_rst");
        idle();
        tick();

        // Burst write then streamed read in bank [1][1].
        for (int c = 0; c < 8; c++) begin
            wr(1, 1, 1, c, burst[c]);
            tick();
        end
        idle();
        for (int c = 0; c < 8; c++) begin
            rd(1, 1, 1, c, burst[c], 1'b0);
            tick();
        end
        idle();
        drain();

        // Bank isolation: [0][0] never saw the burst.
        rd(1, 1, 1, 0, 4'h3, 1'b0);
        rd(0, 0, 1, 0, 4'h3, 1'b1);
        tick();
        idle();
        drain();

        // Concurrent write in [2][3] and read in [1][1].
        wr(2, 3, 4, 1023, 4'h7);
        rd(1, 1, 1, 2, 4'hD, 1'b0);
        tick();
        idle();
        rd(2, 3, 4, 1023, 4'h7, 1'b0);
        tick();
        idle();
        drain();

        // Row aliasing modulo emulated row count.
        wr(1, 1, 1, 5, 4'hA);
        tick();
        idle();
        rd(1, 1, 1 + EMU_ROWS, 5, 4'hA, 1'b0);
        tick();
        idle();
        drain();

        // Async reset in the middle of a read burst.
        for (int c = 0; c < 3; c++) begin
            rd(1, 1, 1, c, burst[c], 1'b0);
            tick();
        end
        rd(1, 1, 1, 3, burst[3], 1'b0);
        reset_n = 1'b0;
        #2;
        check_all_zero("async_rst");
        q.delete();
        tick();
        check("rst_hold", 32'(dqout[1][1]), 32'd0);
        reset_n = 1'b1;
        idle();
        rd(1, 1, 1, 3, 4'h5, 1'b0);
        tick();
        idle();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
